// File: rtl/regfile.sv
// ---------------------------------------------------------------------------
// regfile -- LEGv8 integer register file (X0..X31), decode stage.
//
// Two combinational read ports and one synchronous write port. Read port 1
// feeds ALU operand a. Read port 2 feeds operand b or store data. The write
// port is driven by writeback.
//
// Register ZREG (X31 = XZR) is hardwired to zero. Writes to it are dropped,
// and reads of it always return zero.
//
// Optional feature: define REGFILE_BYPASS_EN to enable write-through bypass.
// With bypass, a read of the register being written in this cycle returns
// wd3 before the clock edge. This removes the writeback->decode hazard.
// Bypass never overrides XZR or reset.
//
// Ports
//   clk    in   1   system clock, rising edge active
//   reset  in   1   asynchronous reset, active-high; clears every register
//   ra1    in   AW  read address, port 1
//   ra2    in   AW  read address, port 2
//   wa3    in   AW  write address
//   wd3    in   N   write data (stored verbatim)
//   we3    in   1   write enable, sampled on the rising clk edge
//   rd1    out  N   read data, port 1
//   rd2    out  N   read data, port 2
// ---------------------------------------------------------------------------
module regfile #(
    parameter int N     = 64,
    parameter int NREGS = 32,
    parameter int ZREG  = 31,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] ra1,
    input  logic [AW-1:0] ra2,
    input  logic [AW-1:0] wa3,
    input  logic [N-1:0]  wd3,
    input  logic          we3,
    output logic [N-1:0]  rd1,
    output logic [N-1:0]  rd2
);

    // Zero-register index at address width, so compares stay width-exact.
    localparam logic [AW-1:0] ZIDX = AW'(ZREG);

    logic [N-1:0] regs [NREGS];

    // A write that actually lands: enabled, not under reset, not to XZR.
    logic wr_live;
    assign wr_live = we3 && !reset && (wa3 != ZIDX);

    // -----------------------------------------------------------------------
    // Storage. Reset clears every entry immediately. Reset also wins over a
    // write presented in the same cycle. The XZR entry is never written, so
    // it stays at its reset value of zero.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_live) begin
            regs[wa3] <= wd3;
        end
    end

    // -----------------------------------------------------------------------
    // Read ports. Overrides are applied in increasing priority:
    // stored value, then bypass (optional), then XZR / reset forcing zero.
    // The reset term is redundant with the cleared storage. It is kept so
    // the ports show zero even if bypass would otherwise select wd3.
    // -----------------------------------------------------------------------
    always_comb begin
        rd1 = regs[ra1];
`ifdef REGFILE_BYPASS_EN
        if (wr_live && (ra1 == wa3)) begin
            rd1 = wd3;
        end
`endif
        if (reset || (ra1 == ZIDX)) begin
            rd1 = '0;
        end
    end

    always_comb begin
        rd2 = regs[ra2];
`ifdef REGFILE_BYPASS_EN
        if (wr_live && (ra2 == wa3)) begin
            rd2 = wd3;
        end
`endif
        if (reset || (ra2 == ZIDX)) begin
            rd2 = '0;
        end
    end

endmodule
